// File: rtl/xgriscv_mem_pkg.sv
// Shared encodings for the data-memory port: access sizes, responder FSM states, wait-state limit.
package xgriscv_mem_pkg;

    localparam logic [1:0] MEM_SZ_B = 2'b00;
    localparam logic [1:0] MEM_SZ_H = 2'b01;
    localparam logic [1:0] MEM_SZ_W = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int MEM_MAX_WAIT = 15;

    // Encoding 11 is treated as a word access, so bit 1 alone identifies a word.
    function automatic logic mem_sz_is_word(input logic [1:0] sz);
        return sz[1];
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and lane select + sign/zero extension for loads (combinational).
// DMEM_MISALIGN_CHECK_EN: flag misaligned half/word accesses instead of forcing them to alignment.
module dmem_lane_align
    import xgriscv_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [1:0]  off;
    logic [31:0] shifted;

    always_comb begin
        off     = 2'b00;
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        if (mem_sz_is_word(size_i)) begin
            off     = 2'b00;
        end else if (size_i == MEM_SZ_H) begin
            off     = {addr_lo_i[1], 1'b0};
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
        end else begin
            off     = addr_lo_i;
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
        end

        shifted = rword_i >> {off, 3'b000};
        if (mem_sz_is_word(size_i)) begin
            rdata_o = rword_i;
        end else if (size_i == MEM_SZ_H) begin
            rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
        end else begin
            rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign_o = mem_sz_is_word(size_i) ? (addr_lo_i != 2'b00)
                                               : ((size_i == MEM_SZ_H) & addr_lo_i[0]);
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, WAIT_CYCLES wait states, response held until resp_ready.
// DMEM_MISALIGN_CHECK_EN enables resp_err reporting (see dmem_lane_align); otherwise resp_err stays 0.
module dmem_responder
    import xgriscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_pc_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] resp_pc_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          idle;
    logic          access;
    logic          cur_we;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [1:0]    cur_size;
    logic          cur_uns;
    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wdata_al;
    logic [31:0]   rdata_al;
    logic          misalign;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^req_addr_i[31:AW+2];

    // With zero wait states the access happens on the acceptance edge, so steer from the live request.
    assign idle      = (state_q == ST_IDLE);
    assign cur_we    = idle ? req_we_i             : we_q;
    assign cur_addr  = idle ? req_addr_i[AW+1:0]   : addr_q;
    assign cur_wdata = idle ? req_wdata_i          : wdata_q;
    assign cur_size  = idle ? req_size_i           : size_q;
    assign cur_uns   = idle ? req_unsigned_i       : uns_q;

    assign access = rst_ni & ((idle & req_valid_i & (WAIT_CYCLES == 0)) |
                              ((state_q == ST_WAIT) & (cnt_q == 4'd0)));

    assign idx   = cur_addr[AW+1:2];
    assign rword = mem_q[idx];

    dmem_lane_align u_align (
        .size_i     (cur_size),
        .addr_lo_i  (cur_addr[1:0]),
        .unsigned_i (cur_uns),
        .wdata_i    (cur_wdata),
        .rword_i    (rword),
        .be_o       (be),
        .wdata_o    (wdata_al),
        .rdata_o    (rdata_al),
        .misalign_o (misalign)
    );

    // The array has no reset; a store pending in WAIT is dropped because reset leaves WAIT first.
    always_ff @(posedge clk_i) begin
        if (access && cur_we && !misalign) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_al[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i[AW+1:0];
                    wdata_d = req_wdata_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    pc_d    = req_pc_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (access) begin
            rdata_d = (cur_we || misalign) ? 32'h0 : rdata_al;
            err_d   = misalign;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            size_q  <= MEM_SZ_W;
            uns_q   <= 1'b0;
            pc_q    <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o  = idle;
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_pc_o    = pc_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_CYCLES=2 and DEPTH_WORDS=1024.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_pc = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] resp_pc;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_pc_i       (req_pc),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .resp_pc_o      (resp_pc)
    );

    always #5 clk = ~clk;

    // lat = number of edges from acceptance to the edge that first samples resp_valid high.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input logic [31:0] pc,
                          output logic [31:0] rdata, output logic err, output logic [31:0] rpc,
                          output int lat);
        int n;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns; req_pc = pc; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (resp_valid !== 1'b1 && lat < 50);
        lat = lat + 1;
        @(negedge clk);
        rdata = resp_rdata; err = resp_err; rpc = resp_pc;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", resp_err); end
        checks++; if (resp_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", resp_pc); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word;
        logic [31:0] rd, pc; logic er; int lat;
        do_req(1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 32'h1000, rd, er, pc, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h want 0", rd); end
        checks++; if (pc !== 32'h1000) begin errors++; $display("FAIL sw_pc got %h want 1000", pc); end
        do_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'h1004, rd, er, pc, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got %b want 0", er); end
        checks++; if (pc !== 32'h1004) begin errors++; $display("FAIL lw_pc got %h want 1004", pc); end
    endtask

    task automatic test_byte;
        logic [31:0] rd, pc; logic er; int lat;
        do_req(1'b1, 32'h101, 32'h0000007F, 2'b00, 1'b0, 32'h1010, rd, er, pc, lat);
        do_req(1'b0, 32'h101, 32'h0, 2'b00, 1'b0, 32'h1014, rd, er, pc, lat);
        checks++; if (rd !== 32'h0000007F) begin errors++; $display("FAIL lb_7f got %h want 0000007f", rd); end
        do_req(1'b1, 32'h102, 32'hFFFFFF80, 2'b00, 1'b0, 32'h1018, rd, er, pc, lat);
        do_req(1'b0, 32'h102, 32'h0, 2'b00, 1'b0, 32'h101C, rd, er, pc, lat);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_80 got %h want ffffff80", rd); end
        do_req(1'b0, 32'h102, 32'h0, 2'b00, 1'b1, 32'h1020, rd, er, pc, lat);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_80 got %h want 00000080", rd); end
        do_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'h1024, rd, er, pc, lat);
        checks++; if (rd !== 32'hDE807FEF) begin errors++; $display("FAIL lw_after_sb got %h want de807fef", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd, pc; logic er; int lat;
        do_req(1'b1, 32'h200, 32'h12345678, 2'b10, 1'b0, 32'h1100, rd, er, pc, lat);
        do_req(1'b1, 32'h202, 32'h0000BEEF, 2'b01, 1'b0, 32'h1104, rd, er, pc, lat);
        do_req(1'b0, 32'h202, 32'h0, 2'b01, 1'b0, 32'h1108, rd, er, pc, lat);
        checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh got %h want ffffbeef", rd); end
        do_req(1'b0, 32'h202, 32'h0, 2'b01, 1'b1, 32'h110C, rd, er, pc, lat);
        checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu got %h want 0000beef", rd); end
        do_req(1'b0, 32'h200, 32'h0, 2'b00, 1'b1, 32'h1110, rd, er, pc, lat);
        checks++; if (rd !== 32'h00000078) begin errors++; $display("FAIL lbu_200 got %h want 00000078", rd); end
        do_req(1'b0, 32'h201, 32'h0, 2'b00, 1'b1, 32'h1114, rd, er, pc, lat);
        checks++; if (rd !== 32'h00000056) begin errors++; $display("FAIL lbu_201 got %h want 00000056", rd); end
        do_req(1'b0, 32'h200, 32'h0, 2'b11, 1'b1, 32'h1118, rd, er, pc, lat);
        checks++; if (rd !== 32'hBEEF5678) begin errors++; $display("FAIL lw_size11 got %h want beef5678", rd); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd, pc; logic er; int lat; int n;
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h100; req_size = 2'b10; req_unsigned = 1'b0;
        req_pc = 32'h2000; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                // Store offered while the response is stalled must be ignored.
                req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'h55555555;
                req_size = 2'b10; req_pc = 32'h2004; req_valid = 1'b1;
            end
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid c%0d got %b want 1", c, resp_valid); end
            checks++; if (resp_rdata !== 32'hDE807FEF) begin errors++; $display("FAIL hold_rdata c%0d got %h want de807fef", c, resp_rdata); end
            checks++; if (resp_pc !== 32'h2000) begin errors++; $display("FAIL hold_pc c%0d got %h want 2000", c, resp_pc); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_req_ready c%0d got %b want 0", c, req_ready); end
        end
        @(negedge clk);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_handshake_ready got %b want 1", req_ready); end
        do_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'h2008, rd, er, pc, lat);
        checks++; if (rd !== 32'hDE807FEF) begin errors++; $display("FAIL ignored_store got %h want de807fef", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd, pc; logic er; int lat; int n;
        do_req(1'b1, 32'h300, 32'h22222222, 2'b10, 1'b0, 32'h3000, rd, er, pc, lat);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h300; req_wdata = 32'h11111111;
        req_size = 2'b10; req_pc = 32'h3004; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wait_rst_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL wait_rst_valid got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL wait_rst_rdata got %h want 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL wait_rst_err got %b want 0", resp_err); end
        checks++; if (resp_pc !== 32'h0) begin errors++; $display("FAIL wait_rst_pc got %h want 0", resp_pc); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 32'h3008, rd, er, pc, lat);
        checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL store_discarded got %h want 22222222", rd); end
        // Reset while a response is being held drops resp_valid without waiting for a clock.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h300; req_pc = 32'h300C; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_rst_valid got %b want 0", resp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_misalign;
        logic [31:0] rd, pc; logic er; int lat;
        do_req(1'b0, 32'h302, 32'h0, 2'b10, 1'b0, 32'h4000, rd, er, pc, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL mis_latency got %0d want 3", lat); end
`ifdef DMEM_MISALIGN_CHECK_EN
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_lw_err got %b want 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_lw_rdata got %h want 0", rd); end
        do_req(1'b1, 32'h301, 32'h0000ABCD, 2'b01, 1'b0, 32'h4004, rd, er, pc, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_sh_err got %b want 1", er); end
        do_req(1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 32'h4008, rd, er, pc, lat);
        checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL mis_sh_mem got %h want 22222222", rd); end
`else
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL mis_lw_err got %b want 0", er); end
        checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL mis_lw_rdata got %h want 22222222", rd); end
        do_req(1'b1, 32'h301, 32'h0000ABCD, 2'b01, 1'b0, 32'h4004, rd, er, pc, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL mis_sh_err got %b want 0", er); end
        do_req(1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 32'h4008, rd, er, pc, lat);
        checks++; if (rd !== 32'h2222ABCD) begin errors++; $display("FAIL mis_sh_mem got %h want 2222abcd", rd); end
`endif
    endtask

    task automatic test_wrap;
        logic [31:0] rd, pc; logic er; int lat;
        do_req(1'b0, 32'h0000_1100, 32'h0, 2'b10, 1'b0, 32'h5000, rd, er, pc, lat);
        checks++; if (rd !== 32'hDE807FEF) begin errors++; $display("FAIL wrap_lw got %h want de807fef", rd); end
        do_req(1'b1, 32'hFFFF_F3FC, 32'hCAFEF00D, 2'b10, 1'b0, 32'h5004, rd, er, pc, lat);
        do_req(1'b0, 32'h0000_03FC, 32'h0, 2'b10, 1'b0, 32'h5008, rd, er, pc, lat);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_top got %h want cafef00d", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_backpressure();
        test_reset_mid();
        test_misalign();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
